// File: rtl/pipe_ripple_adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: stage count and
// configuration legality, both evaluated at elaboration time.
package pipe_ripple_adder_pkg;

  // Number of CHUNK-bit carry slices, hence pipeline stages, in a WIDTH-bit add.
  function automatic int calc_stages(input int width, input int chunk);
    return (chunk >= 1) ? (width / chunk) : 1;
  endfunction

  // A legal configuration splits WIDTH into a whole number of non-empty chunks.
  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice. It also exposes the carry into
// its top bit so the last slice can produce the signed-overflow flag.
module adder_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    c_top = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_top = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_ripple_adder.sv
// WIDTH-bit adder/subtractor built from a chain of CHUNK-bit ripple slices,
// one slice per pipeline stage, with global-stall valid/ready flow control.
module pipe_ripple_adder
  import pipe_ripple_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("pipe_ripple_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Handshake: a beat transfers on any rising edge where valid & ready are both
  // high. The whole pipe advances together (adv) whenever the output slot is
  // empty or being drained; otherwise every stage holds, so in_ready = adv.
  logic adv;

  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] st_c;
  logic              st_ctop;
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];

  logic [STAGES-1:0] nxt_valid;
  logic [STAGES-1:0] nxt_c;
  logic              nxt_ctop [STAGES];
  logic [WIDTH-1:0]  nxt_a    [STAGES];
  logic [WIDTH-1:0]  nxt_b    [STAGES];
  logic [WIDTH-1:0]  nxt_sum  [STAGES];

  assign out_valid = st_valid[STAGES-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             pv;
    logic             pc;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ns;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_ctop;

    if (k == 0) begin : g_head
      // Bubbles enter as all-zero data so an empty output slot never shows
      // garbage. cin is the raw carry into bit 0; in subtract mode it is an
      // active-low borrow, so cin=1 yields a-b.
      assign pv = in_valid;
      assign pa = in_valid ? a : '0;
      assign pb = !in_valid ? '0 : (sub ? ~b : b);
      assign pc = in_valid & cin;
      assign ps = '0;
    end else begin : g_body
      assign pv = st_valid[k-1];
      assign pa = st_a[k-1];
      assign pb = st_b[k-1];
      assign pc = st_c[k-1];
      assign ps = st_sum[k-1];
    end

    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a     (pa[k*CHUNK +: CHUNK]),
      .b     (pb[k*CHUNK +: CHUNK]),
      .cin   (pc),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_top (slice_ctop)
    );

    always_comb begin
      ns                   = ps;
      ns[k*CHUNK +: CHUNK] = slice_sum;
    end

    assign nxt_valid[k] = pv;
    assign nxt_c[k]     = slice_cout;
    assign nxt_ctop[k]  = slice_ctop;
    assign nxt_a[k]     = pa;
    assign nxt_b[k]     = pb;
    assign nxt_sum[k]   = ns;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      st_c     <= '0;
      st_ctop  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
      end
    end else if (adv) begin
      st_valid <= nxt_valid;
      st_c     <= nxt_c;
      st_ctop  <= nxt_ctop[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        st_a[k]   <= nxt_a[k];
        st_b[k]   <= nxt_b[k];
        st_sum[k] <= nxt_sum[k];
      end
    end
  end

  assign sum  = st_sum[STAGES-1];
  assign cout = st_c[STAGES-1];
  assign ovf  = st_ctop ^ st_c[STAGES-1];

endmodule
